sid_audio_decimator: RTL and testbench
======================================

# sid_audio_decimator

Rate-conversion stage between the SID voice output smoothing filter and the I2S transmitter. It consumes one 16-bit signed sample per 1 MHz `clk_en` strobe and boxcar-averages 2^LOG2_N samples into one decimated sample. Each decimated sample is buffered in a small FIFO and released on each sample request from the I2S side. Underruns and overflows are counted, not fatal.

## Interface

Parameters:
- `LOG2_N`, 5, log2 of the decimation ratio (32 → 31.25 kHz from 1 MHz)
- `FIFO_LOG2`, 2, log2 of the FIFO depth (4 entries)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `in_en`  in  1  input strobe; `in_sample` is valid on every cycle this is high
- `in_sample`  in  16  signed input sample
- `out_req`  in  1  consumer request; each high cycle is one request
- `out_sample`  out  16  signed output sample, registered
- `fifo_level`  out  FIFO_LOG2+1  current FIFO occupancy, 0..2^FIFO_LOG2
- `overflow_cnt`  out  8  dropped decimated samples, saturating
- `underrun_cnt`  out  8  requests served while FIFO empty, saturating

## Operation

- Accumulator `acc`: signed, 16+LOG2_N bits, so it never overflows. Window counter `cnt`: LOG2_N bits.
- On `in_en` with `cnt != N-1`: `acc <= acc + in_sample`, `cnt <= cnt + 1`.
- On `in_en` with `cnt == N-1`, the window completes:
  - result = (acc + in_sample) >>> LOG2_N, arithmetic shift, rounding toward −∞, low 16 bits taken.
  - The result is pushed into the FIFO.
  - `acc <= 0`, `cnt <= 0`.
- Push when the FIFO is full and no pop occurs in the same cycle: the new result is dropped, FIFO contents are unchanged, and `overflow_cnt` increments (saturates at 255).
- On `out_req`:
  - FIFO non-empty: `out_sample <= head`, head is popped.
  - FIFO empty: `out_sample` holds its value, `underrun_cnt` increments (saturates at 255).
- Simultaneous push and pop with FIFO full: both succeed, level stays at full, no overflow.
- Simultaneous push and request with FIFO empty: no bypass. The request is an underrun, `out_sample` holds, and the pushed sample is stored (level becomes 1).
- FIFO is strictly first-in first-out. Read and write pointers wrap modulo 2^FIFO_LOG2, with an extra bit to distinguish full from empty.
- Reset values: `acc`=0, `cnt`=0, FIFO empty, `fifo_level`=0, `out_sample`=0, `overflow_cnt`=0, `underrun_cnt`=0.
- `rst` asserted mid-window discards the partial window. The next window is counted from the first `in_en` after reset is released.
- `rst` takes priority over `in_en` and `out_req` in the same cycle.

## Timing

- All state updates occur at the rising `clk` edge on which the qualifying strobe is sampled high.
- Window-completing `in_en` at edge k: the result is in the FIFO and `fifo_level` reflects it after edge k.
- `out_req` at edge k: `out_sample`, `fifo_level` and `underrun_cnt` are updated after edge k, so the consumer sees the new sample one cycle after its request.
- No combinational path from any input to any output.
- A request held high for m cycles performs m pops or underruns. The consumer is required to pulse `out_req` for one cycle per sample.
- `in_en` may be high on consecutive cycles. Every high cycle is accumulated; there is no rate limit.

## Test plan

- Reset, then 32 `in_en` with `in_sample`=1000 → `fifo_level`=1. Then one `out_req` → next cycle `out_sample`=1000, `fifo_level`=0, both counters 0.
- Ramp 0..31, then a window of all −1 → FIFO holds 15 then −1. Window of alternating +1/−2 → −16/32 → −0.5 → −1 (floor).
- 5 windows with values 10, 20, 30, 40, 50 and no requests → `fifo_level`=4, `overflow_cnt`=1. 4 requests return 10, 20, 30, 40 in order.
- `out_req` with FIFO empty after `out_sample`=40 → `out_sample` stays 40, `underrun_cnt`=1. 300 further empty requests → `underrun_cnt` saturates at 255.
- FIFO full, window completes in the same cycle as `out_req` → `fifo_level` stays 4, `overflow_cnt` unchanged, popped value is the oldest entry.
- Window of all −32768 → −32768; window of all 32767 → 32767. Assert `rst` after 10 `in_en` of 5000, then 32 `in_en` of 100 → single FIFO entry 100, all counters 0.

Source files
------------

// File: rtl/sid_audio_decimator.sv
// Boxcar decimator for SID audio: averages 2^LOG2_N input samples into one
// output sample and buffers results in a small FIFO drained by I2S requests.
module sid_audio_decimator #(
  parameter int LOG2_N    = 5,
  parameter int FIFO_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  input  logic [15:0]            in_sample,
  input  logic                   out_req,
  output logic [15:0]            out_sample,
  output logic [FIFO_LOG2:0]     fifo_level,
  output logic [7:0]             overflow_cnt,
  output logic [7:0]             underrun_cnt
);

  localparam int AW    = 16 + LOG2_N;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  // Handshake: there is no backpressure in either direction. in_en is a
  // one-cycle valid with no ready (excess results are dropped and counted);
  // every out_req cycle is one request, served from the FIFO or counted as
  // an underrun, with the data appearing on out_sample the following cycle.

  logic signed [AW-1:0]  acc;
  logic [LOG2_N-1:0]     cnt;
  logic [15:0]           mem [DEPTH];
  logic [FIFO_LOG2:0]    wr_ptr;
  logic [FIFO_LOG2:0]    rd_ptr;

  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  shifted;
  logic [15:0]           result;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  full;
  logic                  push_ok;

  always_comb begin
    sum     = acc + {{LOG2_N{in_sample[15]}}, in_sample};
    shifted = sum >>> LOG2_N;
    result  = shifted[15:0];
    push    = in_en && (cnt == CNT_LAST);
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
              (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
    pop     = out_req && !empty;
    // A simultaneous pop frees the slot the write lands in.
    push_ok = push && (!full || pop);
  end

  assign fifo_level = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_sample   <= '0;
      overflow_cnt <= '0;
      underrun_cnt <= '0;
    end else begin
      if (in_en) begin
        if (push) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end

      if (push_ok) begin
        mem[wr_ptr[FIFO_LOG2-1:0]] <= result;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (push && overflow_cnt != 8'hFF) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end

      if (pop) begin
        out_sample <= mem[rd_ptr[FIFO_LOG2-1:0]];
        rd_ptr     <= rd_ptr + 1'b1;
      end else if (out_req && underrun_cnt != 8'hFF) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sid_audio_decimator.sv
// Directed bench for sid_audio_decimator: a window-average/queue model is
// compared against the DUT every cycle, plus literal spot checks.
module tb_sid_audio_decimator;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en;
  logic [15:0] in_sample;
  logic        out_req;
  logic [15:0] out_sample;
  logic [2:0]  fifo_level;
  logic [7:0]  overflow_cnt;
  logic [7:0]  underrun_cnt;

  sid_audio_decimator #(.LOG2_N(5), .FIFO_LOG2(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_en        (in_en),
    .in_sample    (in_sample),
    .out_req      (out_req),
    .out_sample   (out_sample),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt),
    .underrun_cnt (underrun_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // behavioural model
  logic [15:0] exp_q[$];
  int m_out = 0;
  int m_ovf = 0;
  int m_und = 0;
  int win_sum = 0;
  int win_len = 0;

  function automatic int floor_div(input int a, input int b);
    int r;
    r = a % b;
    if (r < 0) r = r + b;
    return (a - r) / b;
  endfunction

  task automatic model_update(input bit r, input bit en, input int s, input bit req);
    int avg;
    logic [15:0] v;
    if (r) begin
      exp_q.delete();
      m_out = 0; m_ovf = 0; m_und = 0; win_sum = 0; win_len = 0;
      return;
    end
    if (req) begin
      if (exp_q.size() > 0) m_out = int'($signed(exp_q.pop_front()));
      else if (m_und < 255) m_und++;
    end
    if (en) begin
      win_sum += s;
      win_len++;
      if (win_len == N) begin
        avg = floor_div(win_sum, N);
        v = avg[15:0];
        if (exp_q.size() < 4) exp_q.push_back(v);
        else if (m_ovf < 255) m_ovf++;
        win_sum = 0;
        win_len = 0;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      check("out_sample", int'($signed(out_sample)), m_out);
      check("fifo_level", int'(fifo_level), exp_q.size());
      check("overflow_cnt", int'(overflow_cnt), m_ovf);
      check("underrun_cnt", int'(underrun_cnt), m_und);
    end
  end

  // driver tasks
  task automatic step(input bit r, input bit en, input int s, input bit req);
    rst = r; in_en = en; in_sample = s[15:0]; out_req = req;
    @(posedge clk);
    #1;
    model_update(r, en, s, req);
    rst = 1'b0; in_en = 1'b0; out_req = 1'b0;
  endtask

  task automatic window(input int v, input bit req_last);
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, v, req_last && (i == N - 1));
  endtask

  task automatic req1();
    step(1'b0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_en = 1'b0; in_sample = '0; out_req = 1'b0;
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    checking = 1'b1;
    @(negedge clk);
    check("reset_out", int'(out_sample), 0);
    check("reset_level", int'(fifo_level), 0);

    // basic window of 1000
    window(1000, 1'b0);
    check("lvl_after_window", int'(fifo_level), 1);
    req1();
    check("first_avg", int'($signed(out_sample)), 1000);
    check("lvl_after_pop", int'(fifo_level), 0);

    // ramp, all -1, alternating +1/-2
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, i, 1'b0);
    window(-1, 1'b0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 1 : -2, 1'b0);
    req1(); check("ramp_avg", int'($signed(out_sample)), 15);
    req1(); check("neg1_avg", int'($signed(out_sample)), -1);
    req1(); check("alt_floor", int'($signed(out_sample)), -1);

    // overflow: five windows, no requests
    for (int k = 1; k <= 5; k++) window(10 * k, 1'b0);
    check("ovf_level", int'(fifo_level), 4);
    check("ovf_cnt", int'(overflow_cnt), 1);
    for (int k = 1; k <= 4; k++) begin
      req1();
      check("fifo_order", int'($signed(out_sample)), 10 * k);
    end

    // underrun and saturation
    req1();
    check("und_hold", int'($signed(out_sample)), 40);
    check("und_one", int'(underrun_cnt), 1);
    for (int i = 0; i < 300; i++) req1();
    check("und_sat", int'(underrun_cnt), 255);

    // full FIFO with simultaneous push and pop
    for (int k = 1; k <= 4; k++) window(k, 1'b0);
    window(5, 1'b1);
    check("full_pp_level", int'(fifo_level), 4);
    check("full_pp_ovf", int'(overflow_cnt), 1);
    check("full_pp_head", int'($signed(out_sample)), 1);
    for (int k = 2; k <= 5; k++) begin
      req1();
      check("full_pp_order", int'($signed(out_sample)), k);
    end

    // extremes
    window(-32768, 1'b0);
    window(32767, 1'b0);
    req1(); check("min_avg", int'($signed(out_sample)), -32768);
    req1(); check("max_avg", int'($signed(out_sample)), 32767);

    // reset mid-window, with strobes in the reset cycle
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 5000, 1'b0);
    step(1'b1, 1'b1, 5000, 1'b1);
    window(100, 1'b0);
    check("rst_level", int'(fifo_level), 1);
    check("rst_ovf", int'(overflow_cnt), 0);
    check("rst_und", int'(underrun_cnt), 0);
    req1();
    check("rst_avg", int'($signed(out_sample)), 100);

    step(1'b0, 1'b0, 0, 1'b0);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
